// File: rtl/alu_iter_exec.sv
// ============================================================================
// alu_iter_exec
// ----------------------------------------------------------------------------
// Multi-cycle ALU execution unit for the EX stage. Takes the 4-bit alu_func
// code from ALU control plus two operands behind a valid/ready handshake and
// returns a registered result. Add, sub, logic and compare finish in one
// cycle. Shifts walk one bit position per cycle unless the barrel shifter
// is compiled in.
//
// Build option:
//   ALU_ITER_FAST_SHIFT_EN  when defined, shifts use a single-cycle barrel
//                           shifter and the SHIFT state and counter vanish.
//
// Parameters:
//   DATA_WIDTH   operand/result width (power of two, >= 8)
//   SHAMT_WIDTH  width of the shift amount taken from in_b
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    request present
//   in_ready    unit idle and able to accept a request
//   alu_func    operation code
//   in_a, in_b  operands; in_b[SHAMT_WIDTH-1:0] is the shift amount
//   out_valid   result present
//   out_ready   consumer takes the result
//   out_result  result value
//   out_zero    out_result == 0
//   out_err     OP_EEE or unrecognised operation code
// ============================================================================
module alu_iter_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_err
);

  // Operation codes shared with ALU control.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_EEE  = 4'd15;

`ifdef ALU_ITER_FAST_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t                 state;
  state_t                 nextState;

  logic [DATA_WIDTH-1:0]  resultReg;
  logic                   zeroReg;
  logic                   errReg;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  shiftStep;
  logic [DATA_WIDTH-1:0]  opResult;
  logic                   opErr;
  logic                   opIsShift;
  logic                   sltSigned;
  logic                   sltUnsigned;

`ifndef ALU_ITER_FAST_SHIFT_EN
  logic [3:0]             funcReg;
  logic [DATA_WIDTH-1:0]  workReg;
  logic [SHAMT_WIDTH-1:0] shiftCnt;
  logic [DATA_WIDTH-1:0]  workNext;
  logic                   goShift;

  // One bit position of a shift; anything other than SLL/SRL is treated as
  // SRA, which is the only other op that ever reaches this function.
  function automatic logic [DATA_WIDTH-1:0] shiftOne(
    input logic [3:0]            func,
    input logic [DATA_WIDTH-1:0] val
  );
    case (func)
      OP_SLL:  shiftOne = {val[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shiftOne = {1'b0, val[DATA_WIDTH-1:1]};
      default: shiftOne = {val[DATA_WIDTH-1], val[DATA_WIDTH-1:1]};
    endcase
  endfunction
`endif

  assign shamt       = in_b[SHAMT_WIDTH-1:0];
  assign sltSigned   = $signed(in_a) < $signed(in_b);
  assign sltUnsigned = in_a < in_b;

  // Handshake flags come straight off the state register so the upstream
  // stall logic sees them without passing through the datapath.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = resultReg;
  assign out_zero   = zeroReg;
  assign out_err    = errReg;

`ifdef ALU_ITER_FAST_SHIFT_EN
  // Barrel shifter: the whole shift is done in the accept cycle, so every
  // operation has the same one-cycle latency.
  always_comb begin
    shiftStep = '0;
    case (alu_func)
      OP_SLL:  shiftStep = in_a << shamt;
      OP_SRL:  shiftStep = in_a >> shamt;
      default: shiftStep = $unsigned($signed(in_a) >>> shamt);
    endcase
  end
`else
  // The first bit position is shifted already on the accept edge. That way
  // a shift by k costs k cycles in total, matching the one cycle of the
  // simple ops, and a shift by 1 can go straight to DONE. Amount 0 passes
  // the operand through untouched.
  always_comb begin
    shiftStep = in_a;
    if (shamt != '0) begin
      shiftStep = shiftOne(alu_func, in_a);
    end
  end

  // Shifts of two or more positions still have work left after accept and
  // must park in SHIFT; everything else finishes in the accept cycle.
  assign goShift  = opIsShift && (shamt > SHAMT_WIDTH'(1));
  assign workNext = shiftOne(funcReg, workReg);
`endif

  // Decode the operation and compute the single-cycle result. Unknown codes
  // and OP_EEE produce a zero result with the error flag raised, so the
  // handshake still completes and the pipeline never locks up.
  always_comb begin
    opResult  = '0;
    opErr     = 1'b0;
    opIsShift = 1'b0;
    case (alu_func)
      OP_ADD:  opResult = in_a + in_b;
      OP_SUB:  opResult = in_a - in_b;
      OP_XOR:  opResult = in_a ^ in_b;
      OP_OR:   opResult = in_a | in_b;
      OP_AND:  opResult = in_a & in_b;
      OP_SLT:  opResult = {{(DATA_WIDTH-1){1'b0}}, sltSigned};
      OP_SLTU: opResult = {{(DATA_WIDTH-1){1'b0}}, sltUnsigned};
      OP_SLL, OP_SRL, OP_SRA: begin
        opIsShift = 1'b1;
        opResult  = shiftStep;
      end
      OP_EEE:  opErr = 1'b1;
      default: opErr = 1'b1;
    endcase
  end

  // State register. Reset from any state lands in IDLE, which also drops
  // whatever shift was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. Requests are only taken in IDLE, and a new one can
  // only arrive the cycle after the result handshake (no bypass).
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_ITER_FAST_SHIFT_EN
          nextState = DONE;
`else
          nextState = goShift ? SHIFT : DONE;
`endif
        end
      end
`ifndef ALU_ITER_FAST_SHIFT_EN
      SHIFT: begin
        if (shiftCnt == SHAMT_WIDTH'(1)) begin
          nextState = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Result registers. They are written only when a result is produced, so
  // in DONE they hold still for as long as the consumer stalls us, and
  // operand changes outside IDLE have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      resultReg <= '0;
      zeroReg   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_ITER_FAST_SHIFT_EN
            resultReg <= opResult;
            zeroReg   <= (opResult == '0);
            errReg    <= opErr;
`else
            if (!goShift) begin
              resultReg <= opResult;
              zeroReg   <= (opResult == '0);
              errReg    <= opErr;
            end else begin
              errReg    <= 1'b0;
            end
`endif
          end
        end
`ifndef ALU_ITER_FAST_SHIFT_EN
        SHIFT: begin
          if (shiftCnt == SHAMT_WIDTH'(1)) begin
            resultReg <= workNext;
            zeroReg   <= (workNext == '0);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifndef ALU_ITER_FAST_SHIFT_EN
  // Iterative shifter state. The counter holds the number of single-bit
  // steps still to do; the step taken while it reads 1 is the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      funcReg  <= 4'd0;
      workReg  <= '0;
      shiftCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && goShift) begin
            funcReg  <= alu_func;
            workReg  <= shiftStep;
            shiftCnt <= shamt - SHAMT_WIDTH'(1);
          end
        end
        SHIFT: begin
          workReg  <= workNext;
          shiftCnt <= shiftCnt - SHAMT_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_iter_exec.sv
// ============================================================================
// tb_alu_iter_exec
// ----------------------------------------------------------------------------
// Self-checking bench for alu_iter_exec. A table of operations with their
// expected results is driven through the handshake; expected values go into
// a scoreboard queue when a request is accepted and are popped when the
// result appears. Hand-written sequences cover reset state and reset in the
// middle of a long shift.
// ============================================================================
module tb_alu_iter_exec;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_EEE  = 4'd15;

  typedef struct {
    string       name;
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expZero;
    logic        expErr;
    int          hold;
  } vecT;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          lat;
  } sbEntryT;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  int          total = 0;
  int          bad   = 0;
  sbEntryT     sbQueue[$];
  vecT         vecs[19];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  alu_iter_exec #(
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_func   (alu_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  // Expected latency in cycles from the accept edge to out_valid.
  function automatic int expLatency(input logic [3:0] f, input logic [31:0] b);
`ifdef ALU_ITER_FAST_SHIFT_EN
    expLatency = 1;
`else
    if ((f == OP_SLL || f == OP_SRL || f == OP_SRA) && b[4:0] != 5'd0)
      expLatency = int'(b[4:0]);
    else
      expLatency = 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int cycles, output logic [31:0] heldRes);
    sbEntryT e;
    if (sbQueue.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: result with no expected entry, got %h", out_result);
      heldRes = out_result;
      return;
    end
    e = sbQueue.pop_front();
    check({e.name, " result"},  out_result, e.res);
    check({e.name, " zero"},    {31'b0, out_zero}, {31'b0, e.zero});
    check({e.name, " err"},     {31'b0, out_err},  {31'b0, e.err});
    check({e.name, " latency"}, cycles, e.lat);
    heldRes = e.res;
  endtask

  // Drive one request, wait for its result, optionally stall the consumer
  // for 'hold' cycles while poking in_valid, then complete the handshake.
  task automatic applyStimulus(input string name, input logic [3:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic expZero,
                               input logic expErr, input int hold);
    int waited;
    int cycles;
    logic [31:0] heldRes;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check({name, " in_ready before request"}, {31'b0, in_ready}, 32'd1);

    in_valid  = 1'b1;
    alu_func  = f;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    sbQueue.push_back('{name, expRes, expZero, expErr, expLatency(f, b)});
    @(posedge clk); #1;

    in_valid = 1'b0;
    alu_func = 4'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    cycles   = 1;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) check({name, " out_valid timeout"}, {31'b0, out_valid}, 32'd1);
    checkOutput(cycles, heldRes);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      alu_func = 4'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
      @(posedge clk); #1;
      check({name, " held result"},    out_result, heldRes);
      check({name, " held out_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, " held in_ready"},  {31'b0, in_ready},  32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " idle out_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, " idle in_ready"},  {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    vecs[0]  = '{"add wrap",      OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[1]  = '{"sra by 4",      OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 0};
    vecs[2]  = '{"slt neg",       OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0};
    vecs[3]  = '{"sltu big",      OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[4]  = '{"sub backpress", OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 3};
    vecs[5]  = '{"eee",           OP_EEE,  32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[6]  = '{"sll amt 0",     OP_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 0};
    vecs[7]  = '{"xor",           OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 0};
    vecs[8]  = '{"or",            OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 0};
    vecs[9]  = '{"and",           OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 0};
    vecs[10] = '{"sll by 31",     OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 0};
    vecs[11] = '{"srl by 31",     OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 0};
    vecs[12] = '{"srl by 1",      OP_SRL,  32'h80000001, 32'h00000001, 32'h40000000, 1'b0, 1'b0, 0};
    vecs[13] = '{"unknown op",    4'hA,    32'hDEADBEEF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 0};
    vecs[14] = '{"add overflow",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 0};
    vecs[15] = '{"slt pos/neg",   OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 0};
    vecs[16] = '{"sltu pos/neg",  OP_SLTU, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 0};
    vecs[17] = '{"sra positive",  OP_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 2};
    vecs[18] = '{"sll amt masked",OP_SLL,  32'h00000003, 32'h00000025, 32'h00000060, 1'b0, 1'b0, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_func  = 4'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",   {31'b0, in_ready},  32'd1);
    check("reset out_valid",  {31'b0, out_valid}, 32'd0);
    check("reset out_result", out_result,         32'd0);
    check("reset out_zero",   {31'b0, out_zero},  32'd0);
    check("reset out_err",    {31'b0, out_err},   32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] running %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].name, vecs[i].func, vecs[i].a, vecs[i].b,
                    vecs[i].expRes, vecs[i].expZero, vecs[i].expErr, vecs[i].hold);
    end

    // Reset in the middle of a long shift: nothing of it may survive.
    $display("[TB] reset during sll by 31");
    in_valid  = 1'b1;
    alu_func  = OP_SLL;
    in_a      = 32'h00000001;
    in_b      = 32'h0000001F;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midshift reset out_valid",  {31'b0, out_valid}, 32'd0);
    check("midshift reset in_ready",   {31'b0, in_ready},  32'd1);
    check("midshift reset out_result", out_result,         32'd0);
    check("midshift reset out_zero",   {31'b0, out_zero},  32'd0);
    check("midshift reset out_err",    {31'b0, out_err},   32'd0);
    reset = 1'b0;
    applyStimulus("add after reset", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 0);

    check("scoreboard drained", sbQueue.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
# alu_iter_exec

Multi-cycle ALU execution unit that consumes the 4-bit `alu_func` code produced by ALU control, together with two operands, and returns a result. It sits in the EX stage behind a valid/ready handshake, so the datapath can stall on long operations. Add, sub, logic and compare operations complete in one cycle. Shifts run iteratively, one bit position per cycle, unless the fast-shift option is compiled in.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be a power of two, ≥ 8.
- `SHAMT_WIDTH`, $clog2(DATA_WIDTH): width of the shift amount taken from `in_b`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: unit can accept a request.
- `alu_func`, input, 4: operation code (`OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_OR`, `OP_AND`, `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_SLT`, `OP_SLTU`, `OP_EEE` from defines.v).
- `in_a`, input, DATA_WIDTH: operand A.
- `in_b`, input, DATA_WIDTH: operand B; for shifts, shift amount = `in_b[SHAMT_WIDTH-1:0]`.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `out_result`, output, DATA_WIDTH: result.
- `out_zero`, output, 1: `out_result == 0`.
- `out_err`, output, 1: the operation code was `OP_EEE` or unrecognised.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE:
  - On `in_valid && in_ready`, latch `alu_func`, `in_a` and the shift amount.
  - Non-shift op: compute the result into the result register and go to DONE.
  - Shift op with amount 0: result = `in_a`, go to DONE.
  - Shift op with amount > 0: load the working register with `in_a`, load the counter with the amount, go to SHIFT.
- SHIFT, each cycle:
  - Shift the working register by 1: SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB.
  - Decrement the counter.
  - When the counter reaches 1 (last step), go to DONE with the final value.
- DONE: hold `out_result`, `out_zero` and `out_err` stable. On `out_ready`, go to IDLE. There is no bypass: a new request is accepted only in IDLE, on the cycle after the handshake.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - SLT is a signed compare, SLTU an unsigned compare; the result is {0…, 1 bit}.
  - XOR/OR/AND are bitwise.
- Unknown code or `OP_EEE`: `out_result` = 0, `out_zero` = 1, `out_err` = 1. The unit still completes the handshake.
- `alu_func`/`in_a`/`in_b` changes while not in IDLE are ignored.
- Reset at any state, including mid-SHIFT, does the following on the next edge:
  - State goes to IDLE and the in-flight result is discarded.
  - Counter is cleared.
  - Outputs take their reset values: `out_valid` 0, `out_result` 0, `out_zero` 0, `out_err` 0, `in_ready` 1.

## Timing
- Non-shift op, and shift with amount 0: accepted at edge N, `out_valid` = 1 after edge N+1 (latency 1).
- Iterative shift by k > 0: `out_valid` = 1 after edge N+k. Worst case is DATA_WIDTH−1 cycles.
- With `out_ready` held high, throughput is one request per latency+1 cycles.
- Results stay stable for as long as `out_valid && !out_ready` holds.
- All outputs are registered except `in_ready` and `out_valid`, which decode directly from the state register.

## Configuration
- `ALU_ITER_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter in IDLE, and every op has latency 1.
  - The SHIFT state and counter are not compiled.
- Undefined: iterative shifter as described above, latency k.
- Functional results are identical in both builds; only latency differs.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, `out_ready`=1 → `out_valid` one cycle after accept, `out_result`=0, `out_zero`=1, `in_ready` high the cycle after.
- SRA `in_a`=0x80000000, `in_b`=4 → result 0xF8000000; `out_valid` asserts exactly 4 cycles after accept (iterative) or 1 cycle (`ALU_ITER_FAST_SHIFT_EN`).
- SLT `in_a`=0xFFFFFFFF, `in_b`=1 → 1; then SLTU with the same operands → 0, `out_zero`=1.
- Backpressure: SUB 5−7 with `out_ready`=0 for 3 cycles → `out_result`=0xFFFFFFFE held stable, `in_ready`=0 with `in_valid`=1 ignored; release → handshake, then IDLE.
- `alu_func`=`OP_EEE` → `out_err`=1, `out_result`=0; SLL amount 0 (`in_b`=0x20) → result = `in_a`, latency 1.
- Reset asserted mid-SLL by 31 (cycle 10) → next edge: `out_valid`=0, `in_ready`=1; the following ADD 2+3 returns 5 with no residue.
